// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the programmable multi-channel clock divider.
package clkdiv_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_OLD = 2'd1,
        WAIT_NEW = 2'd2
    } sw_state_t;

    localparam logic MODE_PULSE  = 1'b0;
    localparam logic MODE_SQUARE = 1'b1;

    // Square-mode high phase length, ceil(d/2); wide enough that d+1 never overflows.
    function automatic logic [31:0] half_period(input logic [31:0] d);
        return (d + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: wrapping counter, shadowed divisor/mode and output decode.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [DIV_W-1:0] wr_div,
    input  logic             wr_mode,
    output logic             clk_div,
    output logic             period_start,
    output logic             stuck_high
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    logic             mode;
    logic [DIV_W-1:0] shadow;
    logic             shadow_mode;
    logic [DIV_W-1:0] shadow_nxt;
    logic             shadow_mode_nxt;
    logic             wrap;
    logic [DIV_W:0]   half;

    // A write landing on the wrap edge is taken immediately, so the latest value always wins.
    always_comb begin
        shadow_nxt      = shadow;
        shadow_mode_nxt = shadow_mode;
        if (wr_en) begin
            shadow_nxt      = wr_div;
            shadow_mode_nxt = wr_mode;
        end
    end

    // A disabled channel is treated as wrapping every cycle so a new divisor loads at once.
    assign wrap = (div == '0) || (cnt == div - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            div         <= DIV_W'(DEFAULT_DIV);
            mode        <= MODE_PULSE;
            shadow      <= DIV_W'(DEFAULT_DIV);
            shadow_mode <= MODE_PULSE;
        end else begin
            shadow      <= shadow_nxt;
            shadow_mode <= shadow_mode_nxt;
            if (wrap) begin
                cnt  <= '0;
                div  <= shadow_nxt;
                mode <= shadow_mode_nxt;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign half = (DIV_W+1)'(half_period(32'(div)));

    always_comb begin
        clk_div = 1'b0;
        if (div != '0) begin
            if (mode == MODE_SQUARE) begin
                clk_div = ({1'b0, cnt} < half);
            end else begin
                clk_div = (cnt == '0);
            end
        end
    end

    assign period_start = (div != '0) && (cnt == '0);
    assign stuck_high   = (div == DIV_W'(1));

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider with a glitch-free switched dclk output.
module prog_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [$clog2(NUM_CH)-1:0] wr_ch,
    input  logic [DIV_W-1:0]          wr_div,
    input  logic                      wr_mode,
    input  logic [$clog2(NUM_CH)-1:0] sel,
    output logic [NUM_CH-1:0]         clk_div,
    output logic                      dclk,
    output logic [$clog2(NUM_CH)-1:0] sel_cur,
    output logic                      switching
);

    localparam int SEL_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0] period_start;
    logic [NUM_CH-1:0] stuck_high;
    logic              wr_valid;
    logic [SEL_W-1:0]  sel_req;
    sw_state_t         state;
    sw_state_t         state_nxt;
    logic [SEL_W-1:0]  tgt;
    logic [SEL_W-1:0]  tgt_nxt;
    logic [SEL_W-1:0]  sel_cur_nxt;

    assign wr_valid = wr_en && (int'(wr_ch) < NUM_CH);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clkdiv_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .wr_en        (wr_valid && (wr_ch == SEL_W'(i))),
            .wr_div       (wr_div),
            .wr_mode      (wr_mode),
            .clk_div      (clk_div[i]),
            .period_start (period_start[i]),
            .stuck_high   (stuck_high[i])
        );
    end

    // Out-of-range requests are treated as "keep the current source".
    assign sel_req = (int'(sel) < NUM_CH) ? sel : sel_cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            sel_cur <= '0;
            tgt     <= '0;
        end else begin
            state   <= state_nxt;
            sel_cur <= sel_cur_nxt;
            tgt     <= tgt_nxt;
        end
    end

    // A constant-high old source never goes low, so WAIT_OLD gives it a one-cycle timeout.
    always_comb begin
        state_nxt   = state;
        tgt_nxt     = tgt;
        sel_cur_nxt = sel_cur;
        case (state)
            RUN: begin
                if (sel_req != sel_cur) begin
                    tgt_nxt   = sel_req;
                    state_nxt = WAIT_OLD;
                end
            end
            WAIT_OLD: begin
                if (sel_req == sel_cur) begin
                    state_nxt = RUN;
                end else begin
                    tgt_nxt = sel_req;
                    if (!clk_div[sel_cur] || stuck_high[sel_cur]) begin
                        state_nxt = WAIT_NEW;
                    end
                end
            end
            WAIT_NEW: begin
                if (period_start[tgt]) begin
                    sel_cur_nxt = tgt;
                    state_nxt   = RUN;
                end else begin
                    tgt_nxt = sel_req;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        dclk      = 1'b0;
        switching = 1'b0;
        case (state)
            RUN: begin
                dclk = clk_div[sel_cur];
            end
            WAIT_OLD: begin
                dclk      = clk_div[sel_cur];
                switching = 1'b1;
            end
            WAIT_NEW: begin
                dclk      = clk_div[tgt] && period_start[tgt];
                switching = 1'b1;
            end
            default: begin
                dclk      = 1'b0;
                switching = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/prog_clock_divider.md
Name: prog_clock_divider

Overview:
- Parametrised multi-channel clock divider; successor to the fixed /2, /3, /4, /8 divider.
- NUM_CH independent channels, each with a runtime-programmable divisor and a pulse/square duty mode.
- Muxed dclk output with glitch-free channel switching.
- Feeds slow tick/clock-enable domains (display scan, debounce, FSM stepping) in the lab top-levels.

Parameters:
- NUM_CH, 4, number of divider channels (2..8).
- DIV_W, 8, divisor/counter width in bits.
- DEFAULT_DIV, 2, per-channel divisor loaded at reset (1..2^DIV_W-1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- wr_en  in  1  divisor/mode write strobe, sampled on posedge clk.
- wr_ch  in  $clog2(NUM_CH)  channel index for the write.
- wr_div  in  DIV_W  new divisor D.
- wr_mode  in  1  0 = pulse mode, 1 = square (about 50 %) mode.
- sel  in  $clog2(NUM_CH)  requested dclk source channel.
- clk_div  out  NUM_CH  per-channel divided outputs.
- dclk  out  1  selected, glitch-free output.
- sel_cur  out  $clog2(NUM_CH)  channel currently driving dclk.
- switching  out  1  high while a source change is pending.

Behaviour:
- Reset (async, rst_n=0):
  - all cnt[i]=0, div[i]=shadow[i]=DEFAULT_DIV, mode[i]=0.
  - sel_cur=0, FSM=RUN, switching=0.
  - clk_div[i]=1 (cnt=0, pulse mode), dclk=1.
- Counter per channel, D=div[i]:
  - D=0: channel disabled; cnt held 0, clk_div[i]=0.
  - D≥1: cnt counts 0..D-1 and wraps to 0. D=1 gives cnt always 0.
- Output per channel (combinational from registered state only):
  - pulse mode: clk_div[i] = (cnt==0). High one cycle per period; D=1 gives constant 1.
  - square mode: clk_div[i] = (cnt < ceil(D/2)). D=3 gives 2 high, 1 low. D=1 gives constant 1.
- Divisor/mode write:
  - wr_en loads shadow[i] and shadow_mode[i] at the clock edge.
  - Active div/mode take the shadow value at the next wrap (cnt==D-1→0), so the current period is never truncated.
  - If the channel is disabled (D=0), the load happens on the next edge and cnt restarts at 0.
  - Writes with wr_ch ≥ NUM_CH are ignored.
  - A second write before the wrap overwrites the shadow; last write wins.
- dclk switch FSM (states RUN, WAIT_OLD, WAIT_NEW):
  - RUN: dclk = clk_div[sel_cur]. When sel≠sel_cur, latch tgt=sel, go to WAIT_OLD, switching=1.
  - WAIT_OLD: dclk follows the old channel until it is low, i.e. at the first cycle with clk_div[sel_cur]=0. Then dclk is forced 0 and the FSM goes to WAIT_NEW.
  - WAIT_NEW: dclk held 0 until the target channel's cnt==0 (start of period). On that cycle sel_cur=tgt, dclk=clk_div[tgt], go to RUN, switching=0.
  - If tgt is disabled, stay in WAIT_NEW with dclk=0 until the target is programmed.
  - sel changes during WAIT_OLD or WAIT_NEW: tgt is re-latched; no restart of WAIT_OLD.
  - If sel returns to sel_cur during WAIT_OLD, abort to RUN with no gap.
  - Old channel stuck high (D=1): WAIT_OLD exits after at most 1 cycle via forced low (timeout counter = 1).
- Width rules:
  - cnt is DIV_W bits unsigned; compare against D-1 with no overflow.
  - ceil(D/2) = (D+1)>>1, computed in DIV_W+1 bits.
- Reset mid-operation: everything returns to reset values immediately (async). Pending shadows and switches are discarded.

Decomposition:
- Shared package (clkdiv_pkg):
  - switch-FSM state enum.
  - MODE_PULSE/MODE_SQUARE constants.
  - function for half-period computation.
- Sub-module clkdiv_channel (counter, shadow registers, output decode), instantiated NUM_CH times by generate.
- Switch FSM and mux live in the top.

Test Plan:
- Reset, then no writes: all clk_div pulse every 2 cycles (1,0,1,0…); dclk=clk_div[0].
- Write ch1 D=5, square mode: after current period ends, clk_div[1] pattern is 1,1,1,0,0 repeating. Check the old period (D=2) completes first.
- Write ch2 D=0: clk_div[2]=0 constant. Then write D=3 pulse: output 1,0,0 starting the cycle after the write.
- sel 0→3 with ch3 D=8 pulse: dclk never has a high shorter than a full source high. switching=1 until ch3 cnt==0, then sel_cur=3.
- sel 0→1, then back to 0 within WAIT_OLD: no dclk gap, switching drops next cycle.
- Assert rst_n=0 mid-switch and mid-period: outputs go to 1 immediately without a clock, sel_cur=0, and shadows are lost after release.
